// File: rtl/logic_gates_pkg.sv
// Shared types and constants for the logic_gates BIST checker and its golden model.
package logic_gates_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int AND_B  = 0;
  localparam int OR_B   = 1;
  localparam int NOT_B  = 2;
  localparam int NAND_B = 3;
  localparam int NOR_B  = 4;
  localparam int XOR_B  = 5;
  localparam int XNOR_B = 6;

  localparam int NUM_GATES = 7;
  localparam int NUM_VEC   = 4;

endpackage

// File: rtl/logic_gates_golden.sv
// Combinational reference for the seven-gate block: (a,b) -> expected gate outputs.
module logic_gates_golden
  import logic_gates_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] expected
);

  always_comb begin
    expected         = '0;
    expected[AND_B]  = a & b;
    expected[OR_B]   = a | b;
    expected[NOT_B]  = ~a;
    expected[NAND_B] = ~(a & b);
    expected[NOR_B]  = ~(a | b);
    expected[XOR_B]  = a ^ b;
    expected[XNOR_B] = ~(a ^ b);
  end

endmodule

// File: rtl/logic_gates_checker.sv
// On-chip self-test for the logic_gates block: sweeps {a,b}, compares all gates to golden.
// Optional first-mismatch capture port is enabled by defining LGC_FIRST_FAIL_EN.
module logic_gates_checker
  import logic_gates_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 a,
  output logic                 b,
  input  logic [NUM_GATES-1:0] gate_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [NUM_GATES-1:0] fail_vec
`ifdef LGC_FIRST_FAIL_EN
  ,
  output logic [9:0]           first_fail
`endif
);

  localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam int               SUM_W    = ERR_W + 5;
  localparam logic [1:0]       V_LAST   = 2'(NUM_VEC - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [1:0]           v;
  logic [NUM_GATES-1:0] golden;
  logic [NUM_GATES-1:0] mism;
  logic [ERR_W-1:0]     err_next;

  function automatic logic [3:0] popcount(input logic [NUM_GATES-1:0] x);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_GATES; i++) n = n + 4'(x[i]);
    return n;
  endfunction

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                               input logic [3:0]       inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + SUM_W'(inc);
    if (sum > SUM_W'(ERR_MAX)) return ERR_MAX;
    return sum[ERR_W-1:0];
  endfunction

  logic_gates_golden u_golden (
    .a        (v[1]),
    .b        (v[0]),
    .expected (golden)
  );

  assign mism     = gate_in ^ golden;
  assign err_next = sat_add(err_count, popcount(mism));
  assign a        = v[1];
  assign b        = v[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      v          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
`ifdef LGC_FIRST_FAIL_EN
      first_fail <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_count  <= '0;
            fail_vec   <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            v          <= '0;
            busy       <= 1'b1;
            cnt        <= '0;
            state      <= SETTLE;
`ifdef LGC_FIRST_FAIL_EN
            first_fail <= '0;
`endif
          end
        end
        SETTLE: begin
          if (cnt == CNT_LAST) state <= CHECK;
          else                 cnt   <= cnt + 1'b1;
        end
        CHECK: begin
          fail_vec  <= fail_vec | mism;
          err_count <= err_next;
`ifdef LGC_FIRST_FAIL_EN
          // bit 0 doubles as the "already captured" flag
          if ((mism != '0) && !first_fail[0]) first_fail <= {v, gate_in, 1'b1};
`endif
          if (v == V_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            v     <= v + 1'b1;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gates_checker.sv
// Self-checking bench for logic_gates_checker with a behavioural gate-block fault model.
module tb_logic_gates_checker;

  localparam int ERR_W = 4;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             a, b;
  logic [6:0]       gate_in;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_count;
  logic [6:0]       fail_vec;
`ifdef LGC_FIRST_FAIL_EN
  logic [9:0]       first_fail;
`endif

  logic [6:0] masks [4];
  logic [1:0] rec_ab   [14];
  logic       rec_busy [14];
  logic       rec_done [14];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_gates_checker #(.SETTLE_CYCLES(2), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .gate_in   (gate_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
`ifdef LGC_FIRST_FAIL_EN
    ,
    .first_fail(first_fail)
`endif
  );

  // Truth-table view of the gates from the number of ones on the inputs.
  function automatic logic [6:0] gate_model(input logic [1:0] vv);
    int ones;
    ones = int'(vv[1]) + int'(vv[0]);
    return {ones != 1, ones == 1, ones == 0, ones != 2, vv[1] == 1'b0, ones > 0, ones == 2};
  endfunction

  always_comb gate_in = gate_model({a, b}) ^ masks[{a, b}];

  function automatic void model(output int errs, output logic [6:0] fv, output logic [9:0] ff);
    errs = 0; fv = '0; ff = '0;
    for (int i = 0; i < 4; i++) begin
      errs += $countones(masks[i]);
      fv |= masks[i];
      if (masks[i] != 0 && ff == 0) ff = {2'(i), gate_model(2'(i)) ^ masks[i], 1'b1};
    end
    if (errs > ERR_MAX) errs = ERR_MAX;
  endfunction

  task automatic sweep(input bit poke);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    rec_ab[0] = {a, b}; rec_busy[0] = busy; rec_done[0] = done;
    for (int k = 1; k <= 13; k++) begin
      if (poke && (k == 3 || k == 8 || k == 12)) start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      rec_ab[k] = {a, b}; rec_busy[k] = busy; rec_done[k] = done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 4; i++) masks[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({a, b} !== 2'b00) begin bad++; $display("FAIL reset_ab got=%b want=00", {a, b}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", pass); end
    total++; if (err_count !== '0) begin bad++; $display("FAIL reset_err got=%0d want=0", err_count); end
    total++; if (fail_vec !== '0) begin bad++; $display("FAIL reset_fail_vec got=%h want=0", fail_vec); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_clean_sweep();
    for (int i = 0; i < 4; i++) masks[i] = '0;
    sweep(1'b0);
    for (int k = 0; k <= 13; k++) begin
      total++;
      if (rec_ab[k] !== ((k < 12) ? 2'(k / 3) : 2'b11)) begin
        bad++; $display("FAIL clean_ab k=%0d got=%b want=%b", k, rec_ab[k], (k < 12) ? 2'(k / 3) : 2'b11);
      end
      total++;
      if (rec_busy[k] !== (k < 12)) begin bad++; $display("FAIL clean_busy k=%0d got=%b", k, rec_busy[k]); end
      total++;
      if (rec_done[k] !== (k >= 12)) begin bad++; $display("FAIL clean_done k=%0d got=%b", k, rec_done[k]); end
    end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL clean_pass got=%b want=1", pass); end
    total++; if (err_count !== '0) begin bad++; $display("FAIL clean_err got=%0d want=0", err_count); end
    total++; if (fail_vec !== '0) begin bad++; $display("FAIL clean_fail_vec got=%h want=0", fail_vec); end
  endtask

  task automatic test_xor_stuck0();
    masks[0] = '0; masks[1] = 7'b0100000; masks[2] = 7'b0100000; masks[3] = '0;
    sweep(1'b0);
    total++; if (err_count !== 4'd2) begin bad++; $display("FAIL xor_err got=%0d want=2", err_count); end
    total++; if (fail_vec !== 7'b0100000) begin bad++; $display("FAIL xor_fail_vec got=%b want=0100000", fail_vec); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL xor_pass got=%b want=0", pass); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL xor_done got=%b want=1", done); end
  endtask

  task automatic test_invert_saturate();
    for (int i = 0; i < 4; i++) masks[i] = 7'h7F;
    sweep(1'b0);
    total++; if (err_count !== 4'(ERR_MAX)) begin bad++; $display("FAIL sat_err got=%0d want=%0d", err_count, ERR_MAX); end
    total++; if (fail_vec !== 7'h7F) begin bad++; $display("FAIL sat_fail_vec got=%h want=7f", fail_vec); end
    total++; if (pass !== 1'b0) begin bad++; $display("FAIL sat_pass got=%b want=0", pass); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) masks[i] = '0;
    sweep(1'b1);
    for (int k = 0; k <= 13; k++) begin
      total++;
      if (rec_ab[k] !== ((k < 12) ? 2'(k / 3) : 2'b11)) begin
        bad++; $display("FAIL b2b_ab k=%0d got=%b", k, rec_ab[k]);
      end
      total++;
      if (rec_done[k] !== (k >= 12)) begin bad++; $display("FAIL b2b_done k=%0d got=%b", k, rec_done[k]); end
      total++;
      if (rec_busy[k] !== (k < 12)) begin bad++; $display("FAIL b2b_busy k=%0d got=%b", k, rec_busy[k]); end
    end
    total++; if (pass !== 1'b1) begin bad++; $display("FAIL b2b_pass got=%b want=1", pass); end
  endtask

  task automatic test_rst_mid_sweep();
    masks[0] = 7'h01; masks[1] = '0; masks[2] = '0; masks[3] = '0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if ({a, b} !== 2'b01) begin bad++; $display("FAIL mid_ab_before got=%b want=01", {a, b}); end
    total++; if (err_count !== 4'd1) begin bad++; $display("FAIL mid_err_before got=%0d want=1", err_count); end
    #2 rst = 1'b1;
    #1;
    total++; if ({a, b, busy, done} !== 4'b0000) begin bad++; $display("FAIL mid_rst_ctrl got=%b want=0000", {a, b, busy, done}); end
    total++; if (err_count !== '0) begin bad++; $display("FAIL mid_rst_err got=%0d want=0", err_count); end
    total++; if (fail_vec !== '0) begin bad++; $display("FAIL mid_rst_fail_vec got=%h want=0", fail_vec); end
    @(negedge clk); rst = 1'b0;
    masks[0] = '0;
    sweep(1'b0);
    total++; if ({done, pass} !== 2'b11) begin bad++; $display("FAIL mid_fresh got=%b want=11", {done, pass}); end
    total++; if (err_count !== '0) begin bad++; $display("FAIL mid_fresh_err got=%0d want=0", err_count); end
  endtask

  task automatic test_not_stuck1();
    int         errs;
    logic [6:0] fv;
    logic [9:0] ff;
    masks[0] = '0; masks[1] = '0; masks[2] = 7'b0000100; masks[3] = 7'b0000100;
    model(errs, fv, ff);
    sweep(1'b0);
    total++; if (err_count !== 4'(errs)) begin bad++; $display("FAIL not1_err got=%0d want=%0d", err_count, errs); end
    total++; if (fail_vec !== 7'b0000100) begin bad++; $display("FAIL not1_fail_vec got=%b want=0000100", fail_vec); end
`ifdef LGC_FIRST_FAIL_EN
    total++; if (first_fail !== ff) begin bad++; $display("FAIL not1_first_fail got=%h want=%h", first_fail, ff); end
`endif
  endtask

  task automatic test_random();
    int         errs;
    logic [6:0] fv;
    logic [9:0] ff;
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 4; i++)
        masks[i] = ($urandom_range(0, 2) == 0) ? 7'($urandom & $urandom) : 7'h00;
      model(errs, fv, ff);
      sweep(1'b0);
      total++; if (err_count !== 4'(errs)) begin bad++; $display("FAIL rnd_err it=%0d got=%0d want=%0d", it, err_count, errs); end
      total++; if (fail_vec !== fv) begin bad++; $display("FAIL rnd_fail_vec it=%0d got=%h want=%h", it, fail_vec, fv); end
      total++; if (pass !== (errs == 0)) begin bad++; $display("FAIL rnd_pass it=%0d got=%b want=%b", it, pass, errs == 0); end
`ifdef LGC_FIRST_FAIL_EN
      total++; if (first_fail !== ff) begin bad++; $display("FAIL rnd_first_fail it=%0d got=%h want=%h", it, first_fail, ff); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_xor_stuck0();
    test_invert_saturate();
    test_back_to_back();
    test_rst_mid_sweep();
    test_not_stuck1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
